// File: rtl/axi4_duth_noc_pkg.sv
// Shared arbitration types and helpers for the NoC / AXI arbiter family.
package axi4_duth_noc_pkg;

    typedef enum logic [1:0] {
        ARB_TYPES_NONE = 2'd0,
        ARB_TYPES_FPA  = 2'd1,
        ARB_TYPES_RR   = 2'd2,
        ARB_TYPES_WRR  = 2'd3
    } ArbForm;

    // Widest request vector onehot_to_bin accepts.
    localparam int MAX_N = 64;

    // Index width for N requesters, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Zero when no bit is set.
    function automatic int unsigned onehot_to_bin(input logic [MAX_N-1:0] oh);
        int unsigned b;
        b = 0;
        for (int unsigned i = 0; i < MAX_N; i++)
            if (oh[i]) b = b | i;
        return b;
    endfunction

endpackage

// File: rtl/wrr_lock_arbitration_rr_search.sv
// Combinational circular search: first request at or after ptr, wrapping N-1 to 0.
module rr_search
    import axi4_duth_noc_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]          reqs,
    input  logic [idx_w(N)-1:0]   ptr,
    output logic [N-1:0]          grant,
    output logic                  anygnt
);

    int best;

    // The winner is the requester at the smallest circular distance from ptr.
    always_comb begin
        // NOTE: every variable written here gets a default first so no latch is inferred.
        best  = N;
        grant = '0;
        for (int i = 0; i < N; i++)
            if (reqs[i] && ((i + N - int'(ptr)) % N) < best)
                best = (i + N - int'(ptr)) % N;
        for (int i = 0; i < N; i++)
            grant[i] = reqs[i] && (((i + N - int'(ptr)) % N) == best);
    end

    assign anygnt = |reqs;

endmodule

// File: rtl/wrr_lock_arbitration.sv
// N-way arbiter with NONE/FPA/RR/WRR policy, runtime weights and packet lock.
module wrr_lock_arbitration
    import axi4_duth_noc_pkg::*;
#(
    parameter int     N        = 4,
    parameter ArbForm ARB_TYPE = ARB_TYPES_WRR,
    parameter int     PRI_RST  = 0,
    parameter int     WEIGHT_W = 4,
    parameter bit     LOCK_EN  = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N-1:0]            reqs,
    input  logic [N*WEIGHT_W-1:0]   weights,
    input  logic                    advance,
    input  logic                    last,
    output logic [N-1:0]            grants,
    output logic                    anygnt,
    output logic [idx_w(N)-1:0]     gnt_idx,
    output logic                    locked
);

    localparam int IW       = idx_w(N);
    localparam bit USE_PTR  = (ARB_TYPE == ARB_TYPES_RR) || (ARB_TYPE == ARB_TYPES_WRR);
    localparam bit HAS_STATE = (ARB_TYPE != ARB_TYPES_NONE);

    logic [IW-1:0]       ptr, ptr_nxt, lock_idx, lock_idx_nxt, search_ptr, win, win_succ;
    logic [WEIGHT_W-1:0] credit, credit_nxt, win_weight, eff_w;
    logic [WEIGHT_W:0]   cnt;
    logic                lock, lock_nxt, srch_any, accept;
    logic [N-1:0]        srch_grant;

    // FPA reuses the circular search with the pointer pinned to 0.
    assign search_ptr = USE_PTR ? ptr : '0;

    rr_search #(.N(N)) u_search (
        .reqs   (reqs),
        .ptr    (search_ptr),
        .grant  (srch_grant),
        .anygnt (srch_any)
    );

    always_comb begin
        grants = '0;
        anygnt = 1'b0;
        win    = '0;
        if (ARB_TYPE == ARB_TYPES_NONE) begin
            grants = reqs;
            anygnt = |reqs;
            win    = IW'(onehot_to_bin(MAX_N'(srch_grant)));
        end else if (lock) begin
            // A held lock is never stolen; an idle holder simply gets nothing.
            for (int i = 0; i < N; i++)
                if (lock_idx == IW'(i)) begin
                    anygnt    = reqs[i];
                    grants[i] = reqs[i];
                end
            win = anygnt ? lock_idx : '0;
        end else begin
            grants = srch_grant;
            anygnt = srch_any;
            win    = IW'(onehot_to_bin(MAX_N'(srch_grant)));
        end
    end

    assign gnt_idx = win;
    assign locked  = lock;

    always_comb begin
        win_weight = '0;
        for (int i = 0; i < N; i++)
            if (win == IW'(i)) win_weight = weights[i*WEIGHT_W +: WEIGHT_W];
        eff_w    = (win_weight == '0) ? WEIGHT_W'(1) : win_weight;
        cnt      = (win == ptr) ? {1'b0, credit} + 1'b1 : (WEIGHT_W+1)'(1);
        win_succ = (win == IW'(N-1)) ? '0 : win + 1'b1;
        accept   = HAS_STATE && advance && anygnt;

        ptr_nxt      = ptr;
        credit_nxt   = credit;
        lock_nxt     = lock;
        lock_idx_nxt = lock_idx;

        if (accept) begin
            if (LOCK_EN) begin
                lock_nxt     = !last;
                lock_idx_nxt = last ? lock_idx : win;
            end
            // Bandwidth accounting is per packet, so it moves only on the closing flit.
            if ((last || !LOCK_EN) && N > 1) begin
                if (ARB_TYPE == ARB_TYPES_RR) begin
                    ptr_nxt = win_succ;
                end else if (ARB_TYPE == ARB_TYPES_WRR) begin
                    if (cnt >= {1'b0, eff_w}) begin
                        ptr_nxt    = win_succ;
                        credit_nxt = '0;
                    end else begin
                        ptr_nxt    = win;
                        credit_nxt = cnt[WEIGHT_W-1:0];
                    end
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr      <= (N > 1) ? IW'(PRI_RST) : '0;
            credit   <= '0;
            lock     <= 1'b0;
            lock_idx <= '0;
        end else begin
            ptr      <= ptr_nxt;
            credit   <= credit_nxt;
            lock     <= lock_nxt;
            lock_idx <= lock_idx_nxt;
        end
    end

endmodule

// File: tb/tb_wrr_lock_arbitration.sv
// Self-checking bench: one DUT per policy sharing stimulus, directed scenarios plus a random run vs. a reference model.
module tb_wrr_lock_arbitration;
    import axi4_duth_noc_pkg::*;

    localparam int N      = 4;
    localparam int WW     = 4;
    localparam int P_NONE = 0;
    localparam int P_FPA  = 1;
    localparam int P_RR   = 2;
    localparam int P_WRR  = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      reqs;
    logic [N*WW-1:0]   weights;
    logic              advance;
    logic              last;

    logic [N-1:0]      d_grants [4];
    logic              d_any    [4];
    logic [1:0]        d_idx    [4];
    logic              d_locked [4];

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state, one set per policy.
    int m_ptr    [4];
    int m_credit [4];
    int m_lidx   [4];
    bit m_lock   [4];

    always #5 clk = ~clk;

    for (genvar p = 0; p < 4; p++) begin : g_dut
        wrr_lock_arbitration #(
            .N        (N),
            .ARB_TYPE (ArbForm'(p)),
            .PRI_RST  (0),
            .WEIGHT_W (WW),
            .LOCK_EN  (1'b1)
        ) u_dut (
            .clk     (clk),
            .rst     (rst),
            .reqs    (reqs),
            .weights (weights),
            .advance (advance),
            .last    (last),
            .grants  (d_grants[p]),
            .anygnt  (d_any[p]),
            .gnt_idx (d_idx[p]),
            .locked  (d_locked[p])
        );
    end

    function automatic logic [7:0] tup(input logic [3:0] g, input logic a, input logic l, input int i);
        return {g, a, l, 2'(i)};
    endfunction

    function automatic logic [7:0] obs(input int p);
        return {d_grants[p], d_any[p], d_locked[p], d_idx[p]};
    endfunction

    task automatic set_in(input logic [3:0] r, input logic a, input logic l);
        reqs    = r;
        advance = a;
        last    = l;
        #1;
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst     = 1'b0;
        reqs    = '0;
        advance = 1'b0;
        last    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] got;
        do_reset();
        for (int p = 0; p < 4; p++) begin
            got = obs(p);
            vectors++;
            if (got !== tup(4'b0000, 1'b0, 1'b0, 0)) begin
                miscompares++;
                $display("FAIL reset_state p%0d: got %b expected %b", p, got, tup(4'b0000, 1'b0, 1'b0, 0));
            end
        end
    endtask

    task automatic test_rr();
        logic [7:0] got;
        logic [7:0] exp;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            set_in(4'b1111, 1'b1, 1'b1);
            exp = tup(4'(1 << (i % 4)), 1'b1, 1'b0, i % 4);
            got = obs(P_RR);
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL rr_rotate[%0d]: got %b expected %b", i, got, exp);
            end
            got = obs(P_FPA);
            vectors++;
            if (got !== tup(4'b0001, 1'b1, 1'b0, 0)) begin
                miscompares++;
                $display("FAIL fpa_lowest[%0d]: got %b expected %b", i, got, tup(4'b0001, 1'b1, 1'b0, 0));
            end
            next_cycle();
        end
    endtask

    task automatic test_wrr();
        int         seq [9] = '{0, 0, 0, 1, 2, 3, 0, 0, 0};
        logic [7:0] got;
        logic [7:0] exp;
        weights = 16'h1113;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            set_in(4'b1111, 1'b1, 1'b1);
            exp = tup(4'(1 << seq[i]), 1'b1, 1'b0, seq[i]);
            got = obs(P_WRR);
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL wrr_weighted[%0d]: got %b expected %b", i, got, exp);
            end
            next_cycle();
        end
    endtask

    task automatic test_lock();
        logic [7:0] got;
        do_reset();
        set_in(4'b0010, 1'b1, 1'b0);
        got = obs(P_RR);
        vectors++;
        if (got !== tup(4'b0010, 1'b1, 1'b0, 1)) begin
            miscompares++;
            $display("FAIL lock_first: got %b expected %b", got, tup(4'b0010, 1'b1, 1'b0, 1));
        end
        next_cycle();
        for (int i = 0; i < 4; i++) begin
            set_in(4'b1111, 1'b1, i == 3);
            got = obs(P_RR);
            vectors++;
            if (got !== tup(4'b0010, 1'b1, 1'b1, 1)) begin
                miscompares++;
                $display("FAIL lock_hold[%0d]: got %b expected %b", i, got, tup(4'b0010, 1'b1, 1'b1, 1));
            end
            next_cycle();
        end
        set_in(4'b1111, 1'b0, 1'b0);
        got = obs(P_RR);
        vectors++;
        if (got !== tup(4'b0100, 1'b1, 1'b0, 2)) begin
            miscompares++;
            $display("FAIL lock_release: got %b expected %b", got, tup(4'b0100, 1'b1, 1'b0, 2));
        end
    endtask

    task automatic test_lock_idle();
        logic [7:0] got;
        do_reset();
        set_in(4'b0100, 1'b1, 1'b0);
        next_cycle();
        set_in(4'b1011, 1'b1, 1'b0);
        got = obs(P_RR);
        vectors++;
        if (got !== tup(4'b0000, 1'b0, 1'b1, 0)) begin
            miscompares++;
            $display("FAIL lock_idle_block: got %b expected %b", got, tup(4'b0000, 1'b0, 1'b1, 0));
        end
        next_cycle();
        set_in(4'b0100, 1'b0, 1'b0);
        got = obs(P_RR);
        vectors++;
        if (got !== tup(4'b0100, 1'b1, 1'b1, 2)) begin
            miscompares++;
            $display("FAIL lock_idle_resume: got %b expected %b", got, tup(4'b0100, 1'b1, 1'b1, 2));
        end
        next_cycle();
    endtask

    task automatic test_weight_zero_reset();
        logic [7:0] got;
        weights = '0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_in(4'b1111, 1'b1, 1'b1);
            got = obs(P_WRR);
            vectors++;
            if (got !== tup(4'(1 << (i % 4)), 1'b1, 1'b0, i % 4)) begin
                miscompares++;
                $display("FAIL wrr_zero_weight[%0d]: got %b expected %b", i, got, tup(4'(1 << (i % 4)), 1'b1, 1'b0, i % 4));
            end
            next_cycle();
        end
        set_in(4'b1000, 1'b1, 1'b0);
        next_cycle();
        set_in(4'b1000, 1'b0, 1'b0);
        got = obs(P_WRR);
        vectors++;
        if (got !== tup(4'b1000, 1'b1, 1'b1, 3)) begin
            miscompares++;
            $display("FAIL lock_on_3: got %b expected %b", got, tup(4'b1000, 1'b1, 1'b1, 3));
        end
        #1;
        rst = 1'b0;
        #1;
        for (int p = P_RR; p <= P_WRR; p++) begin
            got = obs(p);
            vectors++;
            if (got !== tup(4'b1000, 1'b1, 1'b0, 3)) begin
                miscompares++;
                $display("FAIL async_reset_unlock p%0d: got %b expected %b", p, got, tup(4'b1000, 1'b1, 1'b0, 3));
            end
        end
        set_in(4'b1111, 1'b0, 1'b0);
        for (int p = P_RR; p <= P_WRR; p++) begin
            got = obs(p);
            vectors++;
            if (got !== tup(4'b0001, 1'b1, 1'b0, 0)) begin
                miscompares++;
                $display("FAIL reset_ptr p%0d: got %b expected %b", p, got, tup(4'b0001, 1'b1, 1'b0, 0));
            end
        end
        next_cycle();
        rst = 1'b1;
        #1;
    endtask

    task automatic test_none();
        logic [7:0] got;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(4'b0110, 1'b1, i == 2);
            got = obs(P_NONE) & 8'hFC;
            vectors++;
            if (got !== tup(4'b0110, 1'b1, 1'b0, 0)) begin
                miscompares++;
                $display("FAIL none_pass[%0d]: got %b expected %b", i, got, tup(4'b0110, 1'b1, 1'b0, 0));
            end
            next_cycle();
        end
        set_in(4'b0000, 1'b1, 1'b0);
        got = obs(P_NONE);
        vectors++;
        if (got !== tup(4'b0000, 1'b0, 1'b0, 0)) begin
            miscompares++;
            $display("FAIL none_idle: got %b expected %b", got, tup(4'b0000, 1'b0, 1'b0, 0));
        end
        next_cycle();
    endtask

    // Expected outputs from the policy rules: lock holder first, else nearest request in search order.
    function automatic logic [7:0] model_out(input int p, input logic [3:0] r);
        logic [3:0] g;
        logic       a;
        int         idx;
        int         start;
        g   = '0;
        a   = 1'b0;
        idx = 0;
        if (p == P_NONE) begin
            g = r;
            a = |r;
        end else if (m_lock[p]) begin
            if (r[m_lidx[p]]) begin
                g[m_lidx[p]] = 1'b1;
                a            = 1'b1;
                idx          = m_lidx[p];
            end
        end else begin
            start = (p == P_FPA) ? 0 : m_ptr[p];
            for (int k = 0; k < N; k++) begin
                if (!a && r[(start + k) % N]) begin
                    idx    = (start + k) % N;
                    g[idx] = 1'b1;
                    a      = 1'b1;
                end
            end
        end
        return tup(g, a, (p != P_NONE) && m_lock[p], idx);
    endfunction

    task automatic model_update(input int p, input logic [3:0] r, input logic adv, input logic lst);
        logic [7:0] e;
        int         w;
        int         wt;
        int         cnt;
        e = model_out(p, r);
        if (p == P_NONE || !adv || !e[3]) return;
        w = int'(e[1:0]);
        if (lst) m_lock[p] = 1'b0;
        else begin
            m_lock[p] = 1'b1;
            m_lidx[p] = w;
        end
        if (!lst) return;
        if (p == P_RR) m_ptr[p] = (w + 1) % N;
        if (p == P_WRR) begin
            wt  = int'((weights >> (WW * w)) & 16'hF);
            if (wt == 0) wt = 1;
            cnt = (w == m_ptr[p]) ? m_credit[p] + 1 : 1;
            if (cnt >= wt) begin
                m_ptr[p]    = (w + 1) % N;
                m_credit[p] = 0;
            end else begin
                m_ptr[p]    = w;
                m_credit[p] = cnt;
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] got;
        logic [7:0] exp;
        logic [7:0] mask;
        logic [3:0] r;
        logic       a;
        logic       l;
        weights = 16'h2103;
        do_reset();
        for (int p = 0; p < 4; p++) begin
            m_ptr[p]    = 0;
            m_credit[p] = 0;
            m_lidx[p]   = 0;
            m_lock[p]   = 1'b0;
        end
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 9) == 0)
                for (int i = 0; i < N; i++) weights[i*WW +: WW] = 4'($urandom_range(0, 4));
            r = 4'($urandom_range(0, 15));
            a = ($urandom_range(0, 3) != 0);
            l = 1'($urandom_range(0, 1));
            set_in(r, a, l);
            for (int p = 0; p < 4; p++) begin
                mask = (p == P_NONE) ? 8'hFC : 8'hFF;
                exp  = model_out(p, r) & mask;
                got  = obs(p) & mask;
                vectors++;
                if (got !== exp) begin
                    miscompares++;
                    $display("FAIL random[%0d] p%0d reqs=%b: got %b expected %b", c, p, r, got, exp);
                end
            end
            for (int p = 0; p < 4; p++) model_update(p, r, a, l);
            next_cycle();
        end
    endtask

    initial begin
        rst     = 1'b0;
        reqs    = '0;
        weights = '0;
        advance = 1'b0;
        last    = 1'b0;
        @(negedge clk);
        test_reset();
        test_rr();
        test_wrr();
        test_lock();
        test_lock_idle();
        test_weight_zero_reset();
        test_none();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
